// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types for the message-decode slice.
// Holds ring parameters, the Decompress_1 "one" coefficient, the RAM word
// geometry used by msg_decode_ctrl and the sequencer state encoding.
package kyber_pkg;

  localparam int unsigned KYBER_N       = 256;
  localparam int unsigned KYBER_Q       = 3329;
  localparam int unsigned KYBER_R_WIDTH = 12;

  // round(q/2): the coefficient a set message bit decompresses to
  localparam logic [KYBER_R_WIDTH-1:0] KYBER_MSG_ONE = 12'd1665;

  localparam int unsigned MSG_CPW    = 4;                    // coefficients per RAM word
  localparam int unsigned MSG_BYTE_W = 8;
  localparam int unsigned MSG_BYTES  = KYBER_N / MSG_BYTE_W; // 32
  localparam int unsigned MSG_WORDS  = KYBER_N / MSG_CPW;    // 64
  localparam int unsigned MSG_ADDR_W = $clog2(MSG_WORDS);    // 6
  localparam int unsigned MSG_DATA_W = MSG_CPW * KYBER_R_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } msg_dec_state_t;

endpackage

// File: rtl/msg_coeff_unpack.sv
// Combinational Decompress_1 for one RAM word.
// Ports:
//   bits_i [3:0]  four consecutive message bits, bit j -> coefficient j
//   word_o [47:0] {c3,c2,c1,c0}, cj = bits_i[j] ? KYBER_MSG_ONE : 0
module msg_coeff_unpack
  import kyber_pkg::*;
(
  input  logic [MSG_CPW-1:0]    bits_i,
  output logic [MSG_DATA_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned j = 0; j < MSG_CPW; j++) begin
      word_o[KYBER_R_WIDTH*j +: KYBER_R_WIDTH] = bits_i[j] ? KYBER_MSG_ONE : '0;
    end
  end

endmodule

// File: rtl/msg_decode_ctrl.sv
// Kyber message-decode sequencer: collects a 32-byte message from a byte
// stream, expands each bit to 0/1665 and writes the polynomial to poly RAM
// four coefficients per word, then pulses done.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      begin a decode (IDLE only) / drop back to IDLE
//   busy, done        activity flag, one-cycle completion pulse
//   in_byte/in_valid/in_ready   message byte stream (LSB = lowest bit index)
//   wr_en/wr_addr/wr_data/wr_ready  poly RAM write port
module msg_decode_ctrl
  import kyber_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  input  logic [MSG_BYTE_W-1:0] in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [MSG_ADDR_W-1:0] wr_addr,
  output logic [MSG_DATA_W-1:0] wr_data,
  input  logic                  wr_ready
);

  localparam int unsigned BCNT_W = $clog2(MSG_BYTES);

  msg_dec_state_t        state_q;
  logic [BCNT_W-1:0]     byte_cnt_q;
  logic [MSG_ADDR_W-1:0] word_cnt_q;
  logic [KYBER_N-1:0]    msg_q;
  logic [MSG_DATA_W-1:0] unpacked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      msg_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (in_valid) begin
            msg_q[{byte_cnt_q, 3'b000} +: MSG_BYTE_W] <= in_byte;
            // hold the count at its last value so it never exceeds 31
            if (byte_cnt_q == BCNT_W'(MSG_BYTES - 1)) begin
              state_q <= EMIT;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        EMIT: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (wr_ready) begin
            if (word_cnt_q == MSG_ADDR_W'(MSG_WORDS - 1)) begin
              state_q <= DONE;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  msg_coeff_unpack u_unpack (
    .bits_i (msg_q[{word_cnt_q, 2'b00} +: MSG_CPW]),
    .word_o (unpacked)
  );

  // All handshake/status outputs are decoded straight from the state register.
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign in_ready = (state_q == LOAD);
  assign wr_en    = (state_q == EMIT);
  assign wr_addr  = (state_q == EMIT) ? word_cnt_q : '0;
  assign wr_data  = (state_q == EMIT) ? unpacked : '0;

endmodule

// File: tb/tb_msg_decode_ctrl.sv
module tb_msg_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid, wr_ready;
  logic [7:0]  in_byte;
  logic        busy, done, in_ready, wr_en;
  logic [5:0]  wr_addr;
  logic [47:0] wr_data;

  always #5 clk = ~clk;

  msg_decode_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected RAM word straight from the message bytes: coefficient k of the
  // polynomial is 1665 when message bit k is set.
  function automatic logic [47:0] img_word(input byte unsigned b[32], input int a);
    logic [47:0] w;
    int k, bitv;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      k    = 4 * a + j;
      bitv = (b[k / 8] >> (k % 8)) & 1;
      w    = w | (48'(bitv * 1665) << (12 * j));
    end
    return w;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus driver ----------------
  byte unsigned msg[32];
  bit drv_en    = 1'b0;
  int bi        = 0;
  int gap_left  = 0;
  int gap_max   = 0;
  int stall_pct = 0;

  always begin : driver
    bit acc;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      bi++;
      gap_left = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    end
    if (gap_left > 0) begin
      in_valid = 1'b0;
      gap_left--;
    end else begin
      in_valid = drv_en;
    end
    in_byte  = (bi < 32) ? msg[bi] : 8'($urandom);
    wr_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
  end

  // ---------------- behavioural model ----------------
  // ph: 0 idle, 1 collecting bytes, 2 writing words, 3 completion cycle
  int ph = 0, nb = 0, nw = 0;
  byte unsigned mb[32];

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; nb = 0; nw = 0;
    end else begin
      case (ph)
        0: if (start) begin ph = 1; nb = 0; nw = 0; end
        1: if (abort) ph = 0;
           else if (in_valid) begin
             mb[nb] = in_byte;
             nb++;
             if (nb == 32) ph = 2;
           end
        2: if (abort) ph = 0;
           else if (wr_ready) begin
             nw++;
             if (nw == 64) ph = 3;
           end
        default: ph = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          chk_en   = 1'b0;
  bit          pstall   = 1'b0;
  logic [5:0]  pa;
  logic [47:0] pd;
  int          done_cnt = 0;
  logic [47:0] cap[64];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     64'(busy),     64'(ph != 0));
      chk("in_ready", 64'(in_ready), 64'(ph == 1));
      chk("wr_en",    64'(wr_en),    64'(ph == 2));
      chk("done",     64'(done),     64'(ph == 3));
      chk("wr_addr",  64'(wr_addr),  64'((ph == 2) ? nw : 0));
      chk("wr_data",  64'(wr_data),  64'((ph == 2) ? img_word(mb, nw) : 48'h0));
      if (pstall && wr_en) begin
        chk("stall_addr", 64'(wr_addr), 64'(pa));
        chk("stall_data", 64'(wr_data), 64'(pd));
      end
      pstall = wr_en && !wr_ready;
      pa = wr_addr;
      pd = wr_data;
      if (wr_en && wr_ready) cap[wr_addr] = wr_data;
      if (done) done_cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic run_decode(input int gmax, input int spct, input bit pulse_start,
                            output int lat);
    int t0;
    gap_max   = gmax;
    stall_pct = spct;
    bi        = 0;
    gap_left  = 0;
    for (int a = 0; a < 64; a++) cap[a] = 'x;
    drv_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); t0 = cyc; #1 start = 1'b0;
    lat = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
      start = pulse_start && (k % 7 == 3);
    end
    start  = 1'b0;
    drv_en = 1'b0;
    if (lat < 0) chk("done_timeout", 64'(0), 64'(1));
    @(negedge clk);
  endtask

  task automatic check_image(input string tag);
    for (int a = 0; a < 64; a++) chk({tag, "_img"}, 64'(cap[a]), 64'(img_word(msg, a)));
  endtask

  // ---------------- tests ----------------
  initial begin
    int lat, d0;
    bit found;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; wr_ready = 1'b0; in_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy",    64'(busy),     64'(0));
    chk("rst_done",    64'(done),     64'(0));
    chk("rst_in_rdy",  64'(in_ready), 64'(0));
    chk("rst_wr_en",   64'(wr_en),    64'(0));
    chk("rst_wr_addr", 64'(wr_addr),  64'(0));
    chk("rst_wr_data", 64'(wr_data),  64'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: all ones, no stalls
    for (int i = 0; i < 32; i++) msg[i] = 8'hFF;
    run_decode(0, 0, 1'b0, lat);
    chk("t1_latency", 64'(lat), 64'(97));
    chk("t1_addr0",   64'(cap[0]),  64'(48'h681681681681));
    chk("t1_addr63",  64'(cap[63]), 64'(48'h681681681681));
    check_image("t1");

    // 2: 0xA5 pattern
    for (int i = 0; i < 32; i++) msg[i] = 8'hA5;
    run_decode(0, 0, 1'b0, lat);
    chk("t2_even", 64'(cap[10]), 64'(48'h000681000681));
    chk("t2_odd",  64'(cap[11]), 64'(48'h681000681000));
    check_image("t2");

    // 3: single bit, 50% write back-pressure
    for (int i = 0; i < 32; i++) msg[i] = 8'h00;
    msg[0] = 8'h01;
    run_decode(0, 50, 1'b0, lat);
    chk("t3_addr0", 64'(cap[0]), 64'(48'h000000000681));
    chk("t3_addr1", 64'(cap[1]), 64'(48'h0));
    check_image("t3");

    // 4: random message, byte gaps of 0-3 cycles, random stalls
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    run_decode(3, 30, 1'b0, lat);
    check_image("t4");

    // 5: reset in the middle of EMIT
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    gap_max = 0; stall_pct = 0; bi = 0; drv_en = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 6'd20) begin found = 1'b1; break; end
    end
    chk("t5_reach_w20", 64'(found), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy",    64'(busy),    64'(0));
    chk("t5_wr_en",   64'(wr_en),   64'(0));
    chk("t5_wr_data", 64'(wr_data), 64'(0));
    rst = 1'b0; drv_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt), 64'(d0));
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    run_decode(0, 0, 1'b0, lat);
    chk("t5_latency", 64'(lat), 64'(97));
    check_image("t5");

    // 6: abort at byte 10, then start pulses while busy
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    gap_max = 0; stall_pct = 0; bi = 0; drv_en = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bi == 10 && in_ready) begin found = 1'b1; break; end
    end
    chk("t6_reach_b10", 64'(found), 64'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; drv_en = 1'b0;
    chk("t6_idle", 64'(busy), 64'(0));
    repeat (20) @(negedge clk);
    chk("t6_no_done", 64'(done_cnt), 64'(d0));
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    run_decode(0, 0, 1'b1, lat);
    chk("t6_latency", 64'(lat), 64'(97));
    check_image("t6");
    repeat (5) @(negedge clk);
    chk("t6_single_done", 64'(done_cnt), 64'(d0 + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
